// File: rtl/uart_pkg.sv
// Shared UART receiver types: FSM state encoding and error vector bit positions.
// Pure declarations, no latency and no flow control.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam int ERR_PAR = 2;
  localparam int ERR_OVR = 1;
  localparam int ERR_FRM = 0;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: tick at OVS/2-1 (half) or OVS-1 (full), then wraps to 0.
// tick is combinational from the count; clear holds the count at 0, no backpressure.
module uart_bit_timer #(
  parameter int OVS = 16,
  parameter int CW  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic full,
  output logic tick
);

  localparam logic [CW-1:0] HALF_END = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] FULL_END = CW'(OVS - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == (full ? FULL_END : HALF_END));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive control: strobes are combinational from FSM/timer, rx_valid/error registered at frame end.
// rx_valid holds until rd_ack; an unacknowledged frame is overwritten and flagged as overrun.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVS = 16,
  parameter int CW  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       dnum,
  input  logic       snum,
  input  logic       par_en,
  input  logic       par_odd,
  input  logic       rd_ack,
  output logic       sample,
  output logic       shift_en,
  output logic       rx_bit,
  output logic [2:0] bit_idx,
  output logic       frame_done,
  output logic       rx_valid,
  output logic [2:0] error
);

  logic       sync1, sync2;
  rx_state_e  state_q, state_d;
  logic       tick, tmr_clear, tmr_full;
  logic       dnum_l, snum_l, par_en_l, par_odd_l;
  logic       par_acc, frm_err, stop_idx, brk_wait;
  logic [2:0] bit_idx_q, last_idx;
  logic       start_go;
  logic [2:0] err_d;

  assign rx_bit   = sync2;
  assign bit_idx  = bit_idx_q;
  assign tmr_full = (state_q != START);
  assign last_idx = dnum_l ? 3'd7 : 3'd6;
  assign start_go = (state_q == IDLE) && (state_d == START);

  uart_bit_timer #(.OVS(OVS), .CW(CW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .full  (tmr_full),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      state_q <= IDLE;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_clear  = 1'b0;
    sample     = 1'b0;
    shift_en   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_clear = 1'b1;
        // after a break the line must return high before a new start is accepted
        if (!sync2 && !brk_wait) state_d = START;
      end
      START: begin
        sample = tick;
        if (tick) begin
          if (!sync2) begin
            state_d   = DATA;
            tmr_clear = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        sample   = tick;
        shift_en = tick;
        if (tick && bit_idx_q == last_idx) state_d = par_en_l ? PARITY : STOP;
      end
      PARITY: begin
        sample = tick;
        if (tick) state_d = STOP;
      end
      STOP: begin
        sample = tick;
        if (tick && stop_idx == snum_l) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d          = '0;
    err_d[ERR_PAR] = par_en_l && (par_acc != par_odd_l);
    err_d[ERR_OVR] = rx_valid && !rd_ack;
    err_d[ERR_FRM] = frm_err || !sync2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dnum_l    <= 1'b0;
      snum_l    <= 1'b0;
      par_en_l  <= 1'b0;
      par_odd_l <= 1'b0;
      par_acc   <= 1'b0;
      frm_err   <= 1'b0;
      stop_idx  <= 1'b0;
      brk_wait  <= 1'b0;
      bit_idx_q <= 3'd0;
      rx_valid  <= 1'b0;
      error     <= 3'b000;
    end else begin
      if (start_go) begin
        dnum_l    <= dnum;
        snum_l    <= snum;
        par_en_l  <= par_en;
        par_odd_l <= par_odd;
        par_acc   <= 1'b0;
        frm_err   <= 1'b0;
        stop_idx  <= 1'b0;
        bit_idx_q <= 3'd0;
      end
      if (shift_en) bit_idx_q <= (state_d == DATA) ? bit_idx_q + 3'd1 : 3'd0;
      if (sample && (state_q == DATA || state_q == PARITY)) par_acc <= par_acc ^ sync2;
      if (sample && state_q == STOP) begin
        stop_idx <= 1'b1;
        if (!sync2) frm_err <= 1'b1;
      end
      if (frame_done) begin
        brk_wait <= !sync2;
        error    <= err_d;
        rx_valid <= 1'b1;
      end else begin
        if (sync2) brk_wait <= 1'b0;
        if (rd_ack) rx_valid <= 1'b0;
      end
    end
  end

endmodule
